// File: rtl/led_band_pkg.sv
// Shared constants and state type for the LED-band FC-write sequencer.
package led_band_pkg;

    localparam int unsigned FC_WIDTH      = 48;
    localparam int unsigned FCWRTEN_SCLKS = 15;
    localparam int unsigned WRTFC_SCLKS   = 5;
    localparam int unsigned EDGE_W        = 6;

    typedef enum logic [2:0] {
        IDLE,
        FCWRTEN,
        SHIFT,
        WRTFC,
        DONE
    } seq_state_t;

endpackage

// File: rtl/led_band_sclk_gen.sv
// Free-running SCLK generator gated by run, with registered edge strobes.
module led_band_sclk_gen #(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int unsigned HCNT_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;

    // Half-periods below 2 leave no cycle for LAT to settle before a rise.
    if (SCLK_HALF < 2 || SCLK_HALF > 255) begin : g_bad_half
        $error("led_band_sclk_gen: SCLK_HALF must be in 2..255");
    end

    logic [HCNT_W-1:0] hcnt;
    logic              wrap;

    assign wrap = (hcnt == HCNT_W'(SCLK_HALF - 1));

    // Half-period counter and SCLK toggle; strobes coincide with the new SCLK level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt      <= '0;
            sclk      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            if (!run) begin
                hcnt <= '0;
                sclk <= 1'b0;
            end else if (wrap) begin
                hcnt      <= '0;
                sclk      <= ~sclk;
                sclk_rise <= ~sclk;
                sclk_fall <= sclk;
            end else begin
                hcnt <= hcnt + HCNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_band_fc_sequencer.sv
// Issues one FCWRTEN / 48-bit SHIFT / WRTFC command frame per accepted start.
module led_band_fc_sequencer
    import led_band_pkg::*;
#(
    parameter int unsigned SCLK_HALF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic SCLK,
    output logic LAT
);

    seq_state_t        state;
    logic [EDGE_W-1:0] ecnt;
    logic              run;
    logic              sclk_rise;
    logic              sclk_fall;

    // SCLK runs only while a frame is on the wire.
    assign run = (state == FCWRTEN) || (state == SHIFT) || (state == WRTFC);

    led_band_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .sclk      (SCLK),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    // Phase sequencing: count rises, switch LAT on the fall after the last rise of a phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ecnt  <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            LAT   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= FCWRTEN;
                        busy  <= 1'b1;
                        LAT   <= 1'b1;
                        ecnt  <= '0;
                    end
                end
                FCWRTEN: begin
                    if (sclk_rise) begin
                        ecnt <= ecnt + EDGE_W'(1);
                    end
                    if (sclk_fall && ecnt == EDGE_W'(FCWRTEN_SCLKS)) begin
                        LAT   <= 1'b0;
                        ecnt  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_rise) begin
                        ecnt <= ecnt + EDGE_W'(1);
                    end
                    if (sclk_fall && ecnt == EDGE_W'(FC_WIDTH)) begin
                        LAT   <= 1'b1;
                        ecnt  <= '0;
                        state <= WRTFC;
                    end
                end
                WRTFC: begin
                    if (sclk_rise) begin
                        ecnt <= ecnt + EDGE_W'(1);
                    end
                    if (sclk_fall && ecnt == EDGE_W'(WRTFC_SCLKS)) begin
                        LAT   <= 1'b0;
                        ecnt  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ecnt  <= '0;
                    busy  <= 1'b0;
                    LAT   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_band_fc_sequencer.sv
// Self-checking bench for led_band_fc_sequencer (SCLK_HALF=2 and SCLK_HALF=5 instances).
module tb_led_band_fc_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic start_a, busy_a, done_a, sclk_a, lat_a;
    logic start_b, busy_b, done_b, sclk_b, lat_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [47:0] fc_word = 48'hA5A5_0F0F_1234;

    always #5 clk = ~clk;

    led_band_fc_sequencer #(.SCLK_HALF(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .busy(busy_a), .done(done_a), .SCLK(sclk_a), .LAT(lat_a)
    );

    led_band_fc_sequencer #(.SCLK_HALF(5)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .busy(busy_b), .done(done_b), .SCLK(sclk_b), .LAT(lat_b)
    );

    // {SCLK, LAT, busy, done} of the selected instance
    function automatic logic [3:0] obs(input int sel);
        return (sel == 0) ? {sclk_a, lat_a, busy_a, done_a} : {sclk_b, lat_b, busy_b, done_b};
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    task automatic test_reset();
        logic [3:0] o;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (obs(0) !== 4'b0000 || obs(1) !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_state: a=%b b=%b required 0000", obs(0), obs(1));
        end
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            o = obs(0);
            n_cmp++;
            if (o !== 4'b0000) begin
                n_err++;
                $display("FAIL idle_outputs cycle %0d: got %b required 0000", k, o);
            end
        end
        // async reset pulse strictly between clock edges
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs(0) !== 4'b0000) begin
            n_err++;
            $display("FAIL idle_async_rst: got %b required 0000", obs(0));
        end
        #1 rst = 1'b0;
    endtask

    // One full frame; reference derived from the protocol's edge counts and half-period h.
    task automatic run_seq(input int sel, input int h, input int hold, input bit start_in_done,
                           input string tag);
        int total;
        int hi1, lo, hi2;
        logic [47:0] got;
        logic prev_sclk, prev_lat;
        logic [3:0] o, e;
        bit en;
        total = 136 * h + 1;
        hi1 = 0; lo = 0; hi2 = 0;
        got = '0;
        en = 1'b1;
        prev_sclk = 1'b0;
        prev_lat  = 1'b0;
        @(negedge clk);
        set_start(sel, 1'b1);
        for (int k = 0; k <= total + 3; k++) begin
            @(negedge clk);
            o = obs(sel);
            if (k == hold - 1) set_start(sel, 1'b0);
            if (start_in_done && k == total) set_start(sel, 1'b1);
            if (start_in_done && k == total + 1) set_start(sel, 1'b0);
            e[3] = (k < total) && (((k / h) % 2) == 1);
            e[2] = (k < 30 * h + 1) ? 1'b1 : (k < 126 * h + 1) ? 1'b0 : (k < total) ? 1'b1 : 1'b0;
            e[1] = (k < total);
            e[0] = (k == total);
            n_cmp++;
            if (o !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: {SCLK,LAT,busy,done} got %b required %b", tag, k, o, e);
            end
            // setter model: decode frame on SCLK rises
            if (!prev_sclk && o[3]) begin
                n_cmp++;
                if (o[2] !== prev_lat) begin
                    n_err++;
                    $display("FAIL %s lat_setup cycle %0d: LAT %b before rise, %b at rise", tag, k, prev_lat, o[2]);
                end
                if (o[2]) begin
                    if (lo == 0) hi1++;
                    else         hi2++;
                end else begin
                    if (hi1 == 15) en = 1'b0;
                    if (lo < 48) got = {got[46:0], fc_word[47 - lo]};
                    lo++;
                end
            end
            if (!en && hi2 == 5 && !o[2]) en = 1'b1;
            prev_sclk = o[3];
            prev_lat  = o[2];
        end
        n_cmp++;
        if (hi1 != 15 || lo != 48 || hi2 != 5) begin
            n_err++;
            $display("FAIL %s edge_counts: got %0d/%0d/%0d required 15/48/5", tag, hi1, lo, hi2);
        end
        n_cmp++;
        if (got !== fc_word) begin
            n_err++;
            $display("FAIL %s fc_shift: got %h required %h", tag, got, fc_word);
        end
        n_cmp++;
        if (en !== 1'b1) begin
            n_err++;
            $display("FAIL %s setter_en: got %b required 1", tag, en);
        end
        if (start_in_done) begin
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                n_cmp++;
                if (obs(sel) !== 4'b0000) begin
                    n_err++;
                    $display("FAIL %s no_retrigger cycle %0d: got %b required 0000", tag, k, obs(sel));
                end
            end
        end
    endtask

    task automatic test_single();
        run_seq(0, 2, 1, 1'b0, "single_h2");
    endtask

    task automatic test_back_to_back();
        run_seq(0, 2, 10, 1'b1, "held_start_h2");
        repeat ($urandom_range(0, 5)) @(negedge clk);
        run_seq(0, 2, int'($urandom_range(2, 10)), 1'b0, "rand_hold_h2");
    endtask

    task automatic test_reset_mid_shift();
        int rises;
        int k;
        logic prev;
        logic [3:0] o;
        rises = 0;
        prev = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        for (k = 0; k < 1000 && rises < 35; k++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (!prev && sclk_a) rises++;
            prev = sclk_a;
        end
        n_cmp++;
        if (rises != 35) begin
            n_err++;
            $display("FAIL mid_shift_reach: got %0d rises required 35", rises);
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b1 || lat_a !== 1'b0) begin
            n_err++;
            $display("FAIL mid_shift_state: busy=%b LAT=%b required busy=1 LAT=0", busy_a, lat_a);
        end
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs(0) !== 4'b0000) begin
            n_err++;
            $display("FAIL mid_shift_async_rst: got %b required 0000", obs(0));
        end
        #1 rst = 1'b0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            o = obs(0);
            n_cmp++;
            if (o !== 4'b0000) begin
                n_err++;
                $display("FAIL post_rst_quiet cycle %0d: got %b required 0000", j, o);
            end
        end
        run_seq(0, 2, 1, 1'b0, "after_rst_h2");
    endtask

    task automatic test_half5();
        run_seq(1, 5, int'($urandom_range(1, 10)), 1'b0, "single_h5");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_shift();
        test_half5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
